pipeline_fifo_stage: RTL and testbench
======================================

# pipeline_fifo_stage

Parametrised elastic pipeline stage with a DEPTH-entry circular buffer between a valid/ready producer and consumer. It decouples upstream and downstream stalls and sustains one transfer per cycle at DEPTH ≥ 2. `data_in_ready_o` is a registered-state function with no combinational path from `data_out_ready_i`. It is the general-purpose inter-stage buffer for core pipelines and supports a synchronous flush.

## Interface
- DATAWIDTH, 32, payload width in bits (≥1)
- DEPTH, 2, buffer entries (≥1; any value, not restricted to powers of two)
- clk_i  input  1  clock; all state updates on the rising edge
- arst_i  input  1  reset; asynchronous, active-high
- clear_i  input  1  synchronous flush
- data_in_i  input  DATAWIDTH  upstream payload
- data_in_valid_i  input  1  upstream valid
- data_in_ready_o  output  1  stage can accept
- data_out_o  output  DATAWIDTH  downstream payload
- data_out_valid_o  output  1  downstream valid
- data_out_ready_i  input  1  downstream ready
- count_o  output  $clog2(DEPTH+1)  occupied entries

## Operation
- State:
  - mem[DEPTH]
  - wr_ptr, rd_ptr (each $clog2(DEPTH), min 1 bit)
  - count
- Reset values (asynchronous on arst_i):
  - all state is 0, including mem.
  - data_in_ready_o=0, data_out_valid_o=0, data_out_o=0, count_o=0.
- data_in_ready_o = ~arst_i & ~clear_i & (count != DEPTH).
- data_out_valid_o = ~arst_i & ~clear_i & (count != 0).
- data_out_o = mem[rd_ptr], read combinationally from flops.
- Push on data_in_valid_i & data_in_ready_o:
  - mem[wr_ptr] ← data_in_i.
  - wr_ptr advances; it wraps DEPTH-1 → 0.
- Pop on data_out_valid_o & data_out_ready_i:
  - rd_ptr advances with the same wrap rule.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (count==DEPTH): ready is low, so a push is never accepted in that cycle even if a pop occurs. The freed slot shows ready the next cycle.
- Empty (count==0): valid is low; data_out_o holds stale mem content and is don't-care.
- clear_i high:
  - ready and valid are forced low in that cycle, so no handshake can occur.
  - Next edge: count, wr_ptr and rd_ptr ← 0. mem is not cleared.
- clear_i and arst_i have priority over any handshake.
- Order is strictly FIFO; no entry is dropped or duplicated.

## Timing
- Latency: a push at edge N is visible on data_out_o/data_out_valid_o after edge N (1 cycle) when the buffer was empty.
- Throughput:
  - DEPTH ≥ 2: 1 transfer/cycle under continuous valid and ready.
  - DEPTH = 1: 1 transfer per 2 cycles.
- Ready/valid are independent of same-cycle data_in_valid_i/data_out_ready_i.
- Valid, once asserted, is held with stable data until popped, cleared or reset.
- Reset asserted mid-transfer aborts immediately. Outputs are at reset values in the same cycle (asynchronous), and all buffered data is lost.
- First accept is possible on the first edge after arst_i deasserts.

## Configuration
- PIPELINE_FIFO_BYPASS_EN defined:
  - When count==0, data_in_valid_i=1 and data_out_ready_i=1, the payload passes combinationally: data_out_o=data_in_i, data_out_valid_o=1.
  - No write occurs and count stays 0; zero-cycle latency.
  - When count==0, data_out_o=data_in_i and data_out_valid_o=data_in_valid_i, gated by ~arst_i & ~clear_i.
  - data_in_ready_o is unchanged.
- Not defined: no in→out combinational path; minimum latency is 1 cycle.

## Structure
- No shared-package entries. Pointer width, count width and increment are local derived constants.
- One sub-module: `pipeline_fifo_ptr`, a parametrised wrap-at-DEPTH pointer with increment enable, synchronous clear and async reset. It is instantiated twice (wr, rd).

## Test plan
- Reset check: assert arst_i mid-stream with count=2 → same cycle: valid=0, ready=0, count_o=0, data_out_o=0; after release, ready=1 on first cycle.
- Fill/drain, DEPTH=4: push 0x11,0x22,0x33,0x44 with ready_i=0 → ready_o=0 at count_o=4; then ready_i=1 → outputs 0x11..0x44 in order, count_o 4→0.
- Streaming, DEPTH=2: continuous valid for 100 beats (0..99) with ready_i=1 → 100 outputs in order, 1/cycle after the 1-cycle fill latency, count_o ≤ 1.
- Wrap and simultaneous push/pop, DEPTH=3: random valid/ready for 1000 cycles → scoreboard match, count_o stays consistent, pointers wrap 2→0.
- Flush: count=3, clear_i=1 for one cycle with valid_i=1 → no accept; next cycle count_o=0, valid=0, ready=1.
- Bypass (macro defined), empty: data_in_i=0xDEAD, valid_i=1, ready_i=1 → same cycle data_out_o=0xDEAD, valid=1, count_o stays 0. Without the macro → appears one cycle later.

Source files
------------

// File: rtl/pipeline_fifo_ptr.sv
// Wrap-at-DEPTH circular-buffer pointer with increment enable, synchronous clear
// and asynchronous active-high reset. Used for both read and write sides.
module pipeline_fifo_ptr #(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          arst_i,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            // Explicit wrap so non-power-of-two depths never index past the buffer
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/pipeline_fifo_stage.sv
// Elastic valid/ready pipeline stage backed by a DEPTH-entry circular buffer.
// Optional combinational empty-bypass is enabled by defining PIPELINE_FIFO_BYPASS_EN.
module pipeline_fifo_stage #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 clear_i,
    input  logic [DATAWIDTH-1:0] data_in_i,
    input  logic                 data_in_valid_i,
    output logic                 data_in_ready_o,
    output logic [DATAWIDTH-1:0] data_out_o,
    output logic                 data_out_valid_o,
    input  logic                 data_out_ready_i,
    output logic [CW-1:0]        count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 empty;
    logic                 push_en;
    logic                 pop_en;
    logic                 bypass_hit;

    assign empty           = (count_q == '0);
    assign data_in_ready_o = ~arst_i & ~clear_i & (count_q != FULL_COUNT);

`ifdef PIPELINE_FIFO_BYPASS_EN
    always_comb begin
        if (empty) begin
            data_out_o       = arst_i ? '0 : data_in_i;
            data_out_valid_o = ~arst_i & ~clear_i & data_in_valid_i;
        end else begin
            data_out_o       = mem_q[rd_ptr];
            data_out_valid_o = ~arst_i & ~clear_i;
        end
    end
    // A beat that flows straight through never occupies a slot
    assign bypass_hit = empty & data_in_valid_i & data_out_ready_i;
`else
    assign data_out_o       = mem_q[rd_ptr];
    assign data_out_valid_o = ~arst_i & ~clear_i & ~empty;
    assign bypass_hit       = 1'b0;
`endif

    assign push_en = data_in_valid_i & data_in_ready_o & ~bypass_hit;
    assign pop_en  = data_out_valid_o & data_out_ready_i & ~empty;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (push_en && !pop_en) begin
            count_d = count_q + ONE;
        end else if (pop_en && !push_en) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    mem_q[gi] <= '0;
                end else if (push_en && (wr_ptr == PW'(gi))) begin
                    mem_q[gi] <= data_in_i;
                end
            end
        end
    endgenerate

    pipeline_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .clear_i (clear_i),
        .inc_i   (push_en),
        .ptr_o   (wr_ptr)
    );

    pipeline_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .clear_i (clear_i),
        .inc_i   (pop_en),
        .ptr_o   (rd_ptr)
    );

    assign count_o = count_q;

endmodule

// File: tb/tb_pipeline_fifo_stage.sv
// Scoreboard bench for pipeline_fifo_stage (DEPTH=4); expectations follow
// PIPELINE_FIFO_BYPASS_EN when the macro is defined for the build.
module tb_pipeline_fifo_stage;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef PIPELINE_FIFO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst;
    logic          clear;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;

    logic [DW-1:0] sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_pops  = 0;

    always #5 clk = ~clk;

    pipeline_fifo_stage #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .clear_i          (clear),
        .data_in_i        (in_data),
        .data_in_valid_i  (in_valid),
        .data_in_ready_o  (in_ready),
        .data_out_o       (out_data),
        .data_out_valid_o (out_valid),
        .data_out_ready_i (out_ready),
        .count_o          (count)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Checks flags against the model at the negedge, then retires the handshakes
    task automatic cycle();
        logic          exp_ready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        @(negedge clk);
        exp_ready = !clear && (sb_q.size() != DEPTH);
        exp_valid = !clear && ((sb_q.size() != 0) || (BYPASS && in_valid));
        check_val("count", DW'(count), DW'(sb_q.size()));
        check_val("ready", DW'(in_ready), DW'(exp_ready));
        check_val("valid", DW'(out_valid), DW'(exp_valid));
        if (in_valid && exp_ready) sb_q.push_back(in_data);
        if (out_ready && exp_valid) begin
            exp_data = sb_q.pop_front();
            check_val("data", out_data, exp_data);
            n_pops++;
            $display("[TB] pop %h (exp %h)", out_data, exp_data);
        end
        @(posedge clk);
        #1;
        if (clear) sb_q.delete();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        arst = 1'b1; clear = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        #3;
        check_val("rst_ready", DW'(in_ready), 0);
        check_val("rst_valid", DW'(out_valid), 0);
        check_val("rst_count", DW'(count), 0);
        check_val("rst_data", out_data, 0);
        @(posedge clk); #1;
        arst = 1'b0;

        // Fill with consumer stalled, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'((i + 1) * 32'h11), 1'b0);
            cycle();
        end
        drive(1'b1, 32'h55, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) cycle();
        cycle();

        // Streaming: 100 beats must drain in 101 cycles
        n_pops = 0;
        for (int i = 0; i < 101; i++) begin
            drive(i < 100, DW'(i), 1'b1);
            cycle();
        end
        check_val("stream_pops", DW'(n_pops), 100);

        // Random traffic exercising wrap and simultaneous push/pop
        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
            cycle();
        end
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) cycle();

        // Flush with three entries held and a pending push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(32'hA0 + i), 1'b0);
            cycle();
        end
        drive(1'b1, 32'hBEEF, 1'b1);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        cycle();

        // Empty-buffer latency: same cycle with bypass, one cycle later without
        drive(1'b1, 32'hDEAD, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 1'b1);
        cycle();

        // Asynchronous reset with two entries buffered
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, DW'(32'hC0 + i), 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 1'b0);
        #1 arst = 1'b1;
        #1;
        check_val("arst_valid", DW'(out_valid), 0);
        check_val("arst_ready", DW'(in_ready), 0);
        check_val("arst_count", DW'(count), 0);
        check_val("arst_data", out_data, 0);
        sb_q.delete();
        @(posedge clk); #1;
        arst = 1'b0;
        cycle();
        drive(1'b1, 32'h77, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 1'b1);
        cycle();
        check_val("final_empty", DW'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
